sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter Data_width, default 8: width of each stored word.
REQ-002 Parameter Addr_width, default 5: depth is 2**Addr_width entries.
REQ-003 Parameter AF_level, default 2**Addr_width-2: almost_full threshold, legal range 1..depth.
REQ-004 Parameter AE_level, default 2: almost_empty threshold, legal range 0..depth-1.
REQ-005 Parameter FWFT, default 0: read mode, 0 = registered read, 1 = first-word-fall-through.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 Wr_enable  input  1  write request.
REQ-010 data_in  input  Data_width  write data.
REQ-011 Read_enable  input  1  read request (FWFT=0) or pop/acknowledge of the head word (FWFT=1).
REQ-012 data_out  output  Data_width  read data.
REQ-013 full, empty  output  1 each  status flags.
REQ-014 almost_full, almost_empty  output  1 each  threshold flags.
REQ-015 count  output  Addr_width+1  number of stored entries, 0..depth.
REQ-016 overflow, underflow  output  1 each  single-cycle error pulses.

Function
REQ-017 Write accepted iff Wr_enable=1 and full=0: data_in stored at the write pointer, which increments modulo depth.
REQ-018 Read accepted iff Read_enable=1 and empty=0: the read pointer increments modulo depth.
REQ-019 Pointers are Addr_width+1 bits: the MSB is the wrap bit; the low Addr_width bits address storage.
REQ-020 count next = count + write_accepted - read_accepted; simultaneous accepted read and write leaves count unchanged.
REQ-021 full, empty, almost_full and almost_empty are registered and derived from next count: full = (count==depth), empty = (count==0), almost_full = (count>=AF_level), almost_empty = (count<=AE_level).
REQ-022 At full with Wr_enable and Read_enable both high, the read is accepted and the write is rejected; count becomes depth-1.
REQ-023 At empty with Wr_enable and Read_enable both high, the write is accepted and the read is rejected; count becomes 1.
REQ-024 overflow pulses high for exactly one cycle, in the cycle after Wr_enable=1 while full=1.
REQ-025 underflow pulses high for exactly one cycle, in the cycle after Read_enable=1 while empty=1.
REQ-026 FWFT=0: on an accepted read, data_out is loaded with the head word on that edge (1-cycle latency); otherwise data_out holds its value.
REQ-027 FWFT=1: whenever empty=0, data_out presents the head word with no request; an accepted read advances to the next word on the following edge. data_out is don't-care while empty=1.
REQ-028 FWFT=1: a word written into an empty FIFO appears on data_out in the cycle after the write, with empty deasserting in that same cycle.
REQ-029 Rejected reads and writes modify no pointer, count or storage.

Reset
REQ-030 While rst=1 at a clock edge: pointers=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (1 if AF_level=0 is ever permitted), overflow=0, underflow=0, and in FWFT=0 mode data_out=0.
REQ-031 rst overrides any simultaneous Wr_enable or Read_enable; all stored contents become unreachable.
REQ-032 The storage array is not reset.
REQ-033 The first write is accepted on the first edge after rst falls.

Verification (Data_width=8, Addr_width=2, AF_level=3, AE_level=1)
REQ-034 Reset then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_empty clears at count 2; almost_full sets at count 3; full sets at count 4.
REQ-035 Full FIFO, extra write of 0x55 -> overflow high for one cycle, count stays 4; reads then return 0x11,0x22,0x33,0x44 with no 0x55.
REQ-036 Full FIFO, Wr_enable=Read_enable=1 -> 0x11 is read, count=3, full=0, overflow pulses; empty FIFO with both high -> count=1, underflow pulses.
REQ-037 Wrap: write and read 10 words 0x00..0x09 interleaved at steady count 2 -> output order is exact and count never leaves 1..3.
REQ-038 FWFT=1: write 0xA5 into an empty FIFO -> next cycle data_out=0xA5 and empty=0 with no read; Read_enable for 1 cycle -> empty=1, count=0.
REQ-039 rst asserted with count=3 and Wr_enable=1 -> next cycle count=0, empty=1, full=0, no write recorded.

Source files
------------

// File: rtl/sync_fifo_if.sv
// Handshake and status bundle between a FIFO and its user.
// The user side drives requests and write data; the FIFO side returns data and flags.
interface sync_fifo_if #(
  parameter int Data_width = 8,
  parameter int Addr_width = 5
);
  logic                  Wr_enable;
  logic [Data_width-1:0] data_in;
  logic                  Read_enable;
  logic [Data_width-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [Addr_width:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output Wr_enable, data_in, Read_enable,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  Wr_enable, data_in, Read_enable,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered status flags and a selectable read mode
// (registered read or first-word-fall-through).
module sync_fifo #(
  parameter int Data_width = 8,
  parameter int Addr_width = 5,
  parameter int AF_level   = 2**Addr_width - 2,
  parameter int AE_level   = 2,
  parameter int FWFT       = 0
) (
  input logic        clk,
  input logic        rst,
  sync_fifo_if.slave bus
);
  localparam int Depth = 2**Addr_width;
  localparam logic [Addr_width:0] DepthC  = (Addr_width+1)'(Depth);
  localparam logic [Addr_width:0] AfLevel = (Addr_width+1)'(AF_level);
  localparam logic [Addr_width:0] AeLevel = (Addr_width+1)'(AE_level);

  logic [Data_width-1:0] mem_q [Depth];
  logic [Addr_width:0]   wrPtr_q, wrPtr_d;
  logic [Addr_width:0]   rdPtr_q, rdPtr_d;
  logic [Addr_width:0]   count_q, count_d;
  logic                  full_q, empty_q, almostFull_q, almostEmpty_q;
  logic                  overflow_q, underflow_q;
  logic                  wrAcc, rdAcc;

  // The pointer difference, wrap bit included, gives the occupancy 0..depth.
  always_comb begin
    wrAcc   = bus.Wr_enable && !full_q;
    rdAcc   = bus.Read_enable && !empty_q;
    wrPtr_d = wrPtr_q + {{Addr_width{1'b0}}, wrAcc};
    rdPtr_d = rdPtr_q + {{Addr_width{1'b0}}, rdAcc};
    count_d = wrPtr_d - rdPtr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      almostFull_q  <= (AfLevel == '0);
      almostEmpty_q <= 1'b1;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      count_q       <= count_d;
      full_q        <= (count_d == DepthC);
      empty_q       <= (count_d == '0);
      almostFull_q  <= (count_d >= AfLevel);
      almostEmpty_q <= (count_d <= AeLevel);
      overflow_q    <= bus.Wr_enable && full_q;
      underflow_q   <= bus.Read_enable && empty_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wrAcc) begin
      mem_q[wrPtr_q[Addr_width-1:0]] <= bus.data_in;
    end
  end

  // In FWFT mode the head word is shown directly, so a write into an empty
  // FIFO is visible in the same cycle that empty drops.
  generate
    if (FWFT != 0) begin : gFwft
      assign bus.data_out = mem_q[rdPtr_q[Addr_width-1:0]];
    end else begin : gRegRead
      logic [Data_width-1:0] dataOut_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          dataOut_q <= '0;
        end else if (rdAcc) begin
          dataOut_q <= mem_q[rdPtr_q[Addr_width-1:0]];
        end
      end
      assign bus.data_out = dataOut_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almostFull_q;
  assign bus.almost_empty = almostEmpty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Drives a registered-read and an FWFT FIFO with identical stimulus and
// compares both against a queue-based reference model.
module tb_sync_fifo;
  localparam int Dw    = 8;
  localparam int Aw    = 2;
  localparam int Depth = 4;
  localparam int AfLvl = 3;
  localparam int AeLvl = 1;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [Dw-1:0] modelQ[$];
  logic [Dw-1:0] expDout0;
  logic          expOv;
  logic          expUf;

  sync_fifo_if #(.Data_width(Dw), .Addr_width(Aw)) bus0 ();
  sync_fifo_if #(.Data_width(Dw), .Addr_width(Aw)) bus1 ();

  sync_fifo #(.Data_width(Dw), .Addr_width(Aw), .AF_level(AfLvl), .AE_level(AeLvl), .FWFT(0))
    dutReg (.clk(clk), .rst(rst), .bus(bus0));

  sync_fifo #(.Data_width(Dw), .Addr_width(Aw), .AF_level(AfLvl), .AE_level(AeLvl), .FWFT(1))
    dutFwft (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic we, input logic re, input logic rs, input logic [Dw-1:0] din);
    int sz;
    if (rs) begin
      modelQ.delete();
      expOv    = 1'b0;
      expUf    = 1'b0;
      expDout0 = '0;
    end else begin
      sz    = modelQ.size();
      expOv = we && (sz == Depth);
      expUf = re && (sz == 0);
      if (re && sz != 0) expDout0 = modelQ.pop_front();
      if (we && sz != Depth) modelQ.push_back(din);
    end
  endtask

  task automatic checkAll(input string step);
    int sz;
    sz = modelQ.size();
    checkOutput({step, ".count0"}, 32'(bus0.count), sz);
    checkOutput({step, ".full0"}, 32'(bus0.full), 32'(sz == Depth));
    checkOutput({step, ".empty0"}, 32'(bus0.empty), 32'(sz == 0));
    checkOutput({step, ".afull0"}, 32'(bus0.almost_full), 32'(sz >= AfLvl));
    checkOutput({step, ".aempty0"}, 32'(bus0.almost_empty), 32'(sz <= AeLvl));
    checkOutput({step, ".ovf0"}, 32'(bus0.overflow), 32'(expOv));
    checkOutput({step, ".udf0"}, 32'(bus0.underflow), 32'(expUf));
    checkOutput({step, ".dout0"}, 32'(bus0.data_out), 32'(expDout0));
    checkOutput({step, ".count1"}, 32'(bus1.count), sz);
    checkOutput({step, ".empty1"}, 32'(bus1.empty), 32'(sz == 0));
    checkOutput({step, ".full1"}, 32'(bus1.full), 32'(sz == Depth));
    checkOutput({step, ".ovf1"}, 32'(bus1.overflow), 32'(expOv));
    checkOutput({step, ".udf1"}, 32'(bus1.underflow), 32'(expUf));
    if (sz != 0) checkOutput({step, ".dout1"}, 32'(bus1.data_out), 32'(modelQ[0]));
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic rs,
                               input logic [Dw-1:0] din, input string step);
    rst              = rs;
    bus0.Wr_enable   = we;
    bus0.Read_enable = re;
    bus0.data_in     = din;
    bus1.Wr_enable   = we;
    bus1.Read_enable = re;
    bus1.data_in     = din;
    modelStep(we, re, rs, din);
    @(posedge clk);
    #1;
    checkAll(step);
  endtask

  initial begin
    logic [Dw-1:0] fillData [4];
    logic          we, re, rs;
    fillData = '{8'h11, 8'h22, 8'h33, 8'h44};
    modelQ.delete();
    expDout0 = '0;
    expOv    = 1'b0;
    expUf    = 1'b0;

    // Reset with a write request pending: the write must be ignored.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hEE, "reset");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hEE, "reset2");

    foreach (fillData[i]) applyStimulus(1'b1, 1'b0, 1'b0, fillData[i], "fill");
    checkOutput("fill.count_const", 32'(bus0.count), 4);
    checkOutput("fill.full_const", 32'(bus0.full), 1);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'h55, "overflow");
    checkOutput("overflow.pulse", 32'(bus0.overflow), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "overflow_clear");
    checkOutput("overflow.cleared", 32'(bus0.overflow), 0);

    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "drain");
    checkOutput("drain.last_word", 32'(bus0.data_out), 32'h44);

    foreach (fillData[i]) applyStimulus(1'b1, 1'b0, 1'b0, fillData[i], "refill");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h66, "full_both");
    checkOutput("full_both.dout", 32'(bus0.data_out), 32'h11);
    checkOutput("full_both.count", 32'(bus0.count), 3);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "drain2");
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h77, "empty_both");
    checkOutput("empty_both.count", 32'(bus0.count), 1);
    checkOutput("empty_both.udf", 32'(bus0.underflow), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "empty_both_drain");

    // Pointer wrap at a steady occupancy of two.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, "wrap_pre");
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h01, "wrap_pre");
    for (int i = 2; i < 10; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'(i), "wrap");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "wrap_post");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "wrap_post");
    checkOutput("wrap.last_word", 32'(bus0.data_out), 32'h09);

    applyStimulus(1'b1, 1'b0, 1'b0, 8'hA5, "fwft_write");
    checkOutput("fwft_write.dout", 32'(bus1.data_out), 32'hA5);
    checkOutput("fwft_write.empty", 32'(bus1.empty), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, "fwft_hold");
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, "fwft_pop");
    checkOutput("fwft_pop.empty", 32'(bus1.empty), 1);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i), "prerst");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'hDD, "midrst");
    checkOutput("midrst.count", 32'(bus0.count), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'hBE, "post_rst_write");
    checkOutput("post_rst_write.count", 32'(bus0.count), 1);

    // Random traffic, write-heavy then read-heavy so both ends get exercised.
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin
        we = ($urandom_range(0, 3) != 0);
        re = ($urandom_range(0, 3) == 0);
      end else begin
        we = ($urandom_range(0, 3) == 0);
        re = ($urandom_range(0, 3) != 0);
      end
      rs = ($urandom_range(0, 59) == 0);
      applyStimulus(we, re, rs, 8'($urandom), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
